mdu_seq: RTL and testbench



---
 rtl/mdu_seq.sv | 157 +++++++++++++++
 tb/tb_mdu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide, one bit per cycle, with pipeline stall and a one-cycle done pulse.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic            accept;
  logic            is_div;
  logic            a_signed, b_signed;
  logic            in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_abs, in_b_abs;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign accept = start & (state == IDLE) & ~kill;
  assign is_div = funct3[2];

  // MUL/MULH signed both, MULHSU signed a only; DIV/REM signed, *U unsigned
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];

  assign in_a_neg = a_signed & op_a[XLEN-1];
  assign in_b_neg = b_signed & op_b[XLEN-1];
  assign in_a_abs = in_a_neg ? -op_a : op_a;
  assign in_b_abs = in_b_neg ? -op_b : op_b;

  assign div_zero = is_div & (op_b == {XLEN{1'b0}});
  assign div_ovf  = is_div & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = op_a;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : {XLEN{1'b1}};
    end else if (funct3[1]) begin
      special_res = {XLEN{1'b0}};
    end
  end

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_addend = acc[0] ? a_abs : {XLEN{1'b0}};
  assign mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc[XLEN-1:1]};

  // Divide step: acc = {partial remainder, dividend bits becoming quotient}
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;

  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_abs};
  assign div_sub   = div_shift[XLEN-1:0] - b_abs;
  assign div_next  = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                            : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_res;

  assign prod = (a_neg ^ b_neg) ? -acc : acc;
  assign quo  = ((op_q == 3'b100) & (a_neg ^ b_neg)) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = prod[XLEN-1:0];
    case (op_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        if (kill)              state_nxt = IDLE;
        else if (cnt == '0)    state_nxt = FIN;
      end
      FIN:     state_nxt = kill ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= 3'b000;
      a_abs  <= '0;
      b_abs  <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= funct3;
      a_abs <= in_a_abs;
      b_abs <= in_b_abs;
      a_neg <= in_a_neg;
      b_neg <= in_b_neg;
      acc   <= is_div ? {{XLEN{1'b0}}, in_a_abs} : {{XLEN{1'b0}}, in_b_abs};
      cnt   <= CW'(XLEN - 1);
      if (special) result <= special_res;
    end else if (state == CALC && !kill) begin
      acc <= op_q[2] ? div_next : mul_next;
      cnt <= cnt - 1'b1;
    end else if (state == FIN && !kill) begin
      result <= fin_res;
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stall = accept | (state == CALC) | (state == FIN);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: arithmetic results, latency,
// special divide cases, start-while-busy, kill and asynchronous reset.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checkCount = 0;
  int passCount  = 0;

  mdu_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .kill   (kill),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, expected);
    end
  endtask

  // Drives a request at the falling edge of the cycle in which it is sampled
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!done && cyc < 60);
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int cyc;
    applyStimulus(f3, a, b);
    waitDone(cyc);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(expLat));
    checkOutput({tag, "_res"}, result, expRes);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int badStall;
    int doneCyc;
    int killDone;

    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    kill   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy",   32'(busy),  32'd0);
    checkOutput("rst_done",   32'(done),  32'd0);
    checkOutput("rst_stall",  32'(stall), 32'd0);
    checkOutput("rst_result", result,     32'd0);
    rst = 1'b0;

    // MUL 7 * -3 with full stall/latency profile
    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
    #1;
    checkOutput("mul_stall_T", 32'(stall), 32'd1);
    badStall = 0;
    doneCyc  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= 33 && (!stall || done)) badStall++;
      if (done) begin
        doneCyc = k;
        break;
      end
    end
    checkOutput("mul_stall_run",  32'(badStall), 32'd0);
    checkOutput("mul_lat",        32'(doneCyc),  32'd34);
    checkOutput("mul_res",        result,        32'hFFFF_FFEB);
    checkOutput("mul_stall_done", 32'(stall),    32'd0);
    @(negedge clk);
    checkOutput("mul_busy_after", 32'(busy), 32'd0);
    checkOutput("mul_done_after", 32'(done), 32'd0);

    runOp("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    runOp("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    runOp("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
    runOp("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    runOp("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    runOp("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34);
    runOp("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34);

    runOp("div_by0",  3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    runOp("remu_by0", 3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
    runOp("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // A second start mid-operation must not disturb the running MUL
    applyStimulus(3'b000, 32'd5, 32'd6);
    doneCyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin
        funct3 = 3'b000;
        op_a   = 32'd100;
        op_b   = 32'd100;
      end
      if (done) begin
        doneCyc = k;
        break;
      end
    end
    start = 1'b0;
    checkOutput("ignore_lat", 32'(doneCyc), 32'd34);
    checkOutput("ignore_res", result,       32'd30);

    // Kill at T+10 aborts without a done pulse and keeps the old result
    applyStimulus(3'b000, 32'd9, 32'd9);
    killDone = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      kill  = (k == 10);
      if (done) killDone++;
    end
    checkOutput("kill_busy",   32'(busy),     32'd0);
    checkOutput("kill_nodone", 32'(killDone), 32'd0);
    checkOutput("kill_result", result,        32'd30);
    runOp("divu_after_kill", 3'b101, 32'd100, 32'd7, 32'd14, 34);

    // Asynchronous reset in the middle of a DIVU
    applyStimulus(3'b101, 32'd1000, 32'd3);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkOutput("arst_busy",   32'(busy),  32'd0);
    checkOutput("arst_done",   32'(done),  32'd0);
    checkOutput("arst_stall",  32'(stall), 32'd0);
    checkOutput("arst_result", result,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    runOp("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
